// File: rtl/store_buffer.sv
// Posted-write store buffer between the memory stage and the data memory.
// Stores queue in a small FIFO and retire in the background; non-aliasing loads bypass the queue.
module store_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WADDR_HI = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        empty,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    D_IDLE,
    D_ISSUE,
    D_WAIT
  } dstate_t;

  dstate_t state;

  logic [31:0] q_addr [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [3:0]  q_mask [DEPTH];

  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [PW:0]   count;
  logic [PW-1:0] offs;
  logic          full;
  logic          hazard;
  logic          load_issue;
  logic          push;
  logic          pop;

  assign full = (count == DEPTH_C);
  assign push = memwrite & ~full;
  assign pop  = (state == D_WAIT) & ~mem_busy;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    hazard = 1'b0;
    offs   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr[PW-1:0];
      if (({1'b0, offs} < count) && (q_addr[i][WADDR_HI:2] == addr[WADDR_HI:2]))
        hazard = 1'b1;
    end
    hazard = hazard & memread;
  end

  // A combined read+write request is a store, so it never issues a load.
  assign load_issue = memread & ~memwrite & ~hazard & (state == D_IDLE) & ~mem_busy;

  assign stall = memwrite ? full : (memread & ~load_issue);
  assign empty = (count == '0) & (state == D_IDLE);
  assign read_data = mem_read_data;

  always_comb begin
    mem_addr       = addr;
    mem_write_data = write_data;
    mem_sign_mask  = sign_mask;
    mem_memread    = 1'b0;
    mem_memwrite   = 1'b0;
    if (state != D_IDLE) begin
      mem_addr       = q_addr[rd_ptr[PW-1:0]];
      mem_write_data = q_data[rd_ptr[PW-1:0]];
      mem_sign_mask  = q_mask[rd_ptr[PW-1:0]];
      mem_memwrite   = (state == D_ISSUE);
    end else begin
      mem_memread    = load_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr[PW-1:0]] <= addr;
      q_data[wr_ptr[PW-1:0]] <= write_data;
      q_mask[wr_ptr[PW-1:0]] <= sign_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= D_IDLE;
    end else begin
      case (state)
        D_IDLE:  if ((count != '0) && !mem_busy && !load_issue) state <= D_ISSUE;
        D_ISSUE: state <= D_WAIT;
        D_WAIT:  if (!mem_busy) state <= D_IDLE;
        default: state <= D_IDLE;
      endcase
    end
  end

endmodule
